game_timer: RTL and testbench

Countdown game timer and header-rectangle generator for the HUD. It holds the remaining race time as 3 BCD digits, decrements them once per second while a race is running, and flags expiry. It also maps the current VGA pixel onto the 32×16 "TIME" header bitmap stage by producing that stage's `offsetX`/`offsetY`/`InsideRectangle` inputs. The BCD digits feed the HUD digit drawers that sit next to the header.

---
 rtl/road_fighter_pkg.sv | 35 +++
 rtl/bcd3_addsub.sv | 25 ++
 rtl/game_timer.sv | 120 ++++++++++++
 tb/tb_game_timer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/road_fighter_pkg.sv
// rtl/road_fighter_pkg.sv - shared types, screen constants and BCD helpers for the HUD
package road_fighter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_EXPIRED
  } timer_state_t;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BCD3_MAX = 999;

  // Binary 0..999 to three BCD digits
  function automatic bcd3_t to_bcd3(input int unsigned v);
    bcd3_t r;
    r.hundreds = 4'((v / 100) % 10);
    r.tens     = 4'((v / 10) % 10);
    r.ones     = 4'(v % 10);
    return r;
  endfunction

  // Three BCD digits to binary 0..999
  function automatic int unsigned from_bcd3(input bcd3_t b);
    return 32'(b.hundreds) * 100 + 32'(b.tens) * 10 + 32'(b.ones);
  endfunction

endpackage

// File: rtl/bcd3_addsub.sv
// rtl/bcd3_addsub.sv - 3-digit BCD decrement/bonus add, saturating at 999 and flooring at 000
module bcd3_addsub
  import road_fighter_pkg::*;
#(
  parameter int BONUS = 10
) (
  input  bcd3_t value,
  input  logic  dec,
  input  logic  add,
  output bcd3_t result
);

  int sum;

  // Work in binary so a simultaneous decrement and add clamp as one operation
  always_comb begin
    sum = int'(from_bcd3(value));
    if (add) sum = sum + BONUS;
    if (dec) sum = sum - 1;
    if (sum > BCD3_MAX) sum = BCD3_MAX;
    else if (sum < 0)   sum = 0;
    result = to_bcd3(32'(sum));
  end

endmodule

// File: rtl/game_timer.sv
// rtl/game_timer.sv - countdown race timer with BCD digits and TIME header rectangle mapping
module game_timer
  import road_fighter_pkg::*;
#(
  parameter int TICKS_PER_SEC = 31_500_000,
  parameter int START_SECONDS = 150,
  parameter int BONUS_SECONDS = 10,
  parameter int HEADER_X      = 16,
  parameter int HEADER_Y      = 8,
  parameter int HEADER_W      = 32,
  parameter int HEADER_H      = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startGame,
  input  logic        pause,
  input  logic        bonusAdd,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [3:0]  digitHundreds,
  output logic [3:0]  digitTens,
  output logic [3:0]  digitOnes,
  output logic        timerRunning,
  output logic        lowTime,
  output logic        timeUp
);

  localparam int              PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam bcd3_t           START_BCD  = to_bcd3(START_SECONDS);
  localparam logic [11:0]     X_LO       = 12'(HEADER_X);
  localparam logic [11:0]     X_HI       = 12'(HEADER_X + HEADER_W);
  localparam logic [11:0]     Y_LO       = 12'(HEADER_Y);
  localparam logic [11:0]     Y_HI       = 12'(HEADER_Y + HEADER_H);

  timer_state_t  state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  bcd3_t         digits, digits_nxt, addsub_out;
  logic          tick, add_ok, expire, low_nxt;

  // A tick only happens while actually counting; pause freezes it at once
  always_comb begin
    tick   = (state == ST_RUNNING) && !pause && (presc == PRESC_LAST);
    add_ok = bonusAdd && ((state == ST_RUNNING) || (state == ST_PAUSED));
  end

  bcd3_addsub #(.BONUS(BONUS_SECONDS)) u_addsub (
    .value  (digits),
    .dec    (tick),
    .add    (add_ok),
    .result (addsub_out)
  );

  // Next-state decision; startGame overrides everything else in the cycle
  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    digits_nxt = digits;
    expire     = 1'b0;
    if (startGame) begin
      state_nxt  = ST_RUNNING;
      presc_nxt  = '0;
      digits_nxt = START_BCD;
    end else begin
      digits_nxt = addsub_out;
      case (state)
        ST_RUNNING: begin
          if (pause) begin
            state_nxt = ST_PAUSED;
          end else begin
            presc_nxt = tick ? '0 : presc + PW'(1);
            if (tick && (addsub_out == '0)) begin
              state_nxt = ST_EXPIRED;
              expire    = 1'b1;
            end
          end
        end
        ST_PAUSED: if (!pause) state_nxt = ST_RUNNING;
        default: ;
      endcase
    end
    low_nxt = ((state_nxt == ST_RUNNING) || (state_nxt == ST_PAUSED)) &&
              (digits_nxt.hundreds == 4'd0) &&
              ((digits_nxt.tens == 4'd0) ||
               ((digits_nxt.tens == 4'd1) && (digits_nxt.ones == 4'd0)));
  end

  // State, prescaler, digits and flags all registered together
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ST_IDLE;
      presc        <= '0;
      digits       <= START_BCD;
      timerRunning <= 1'b0;
      lowTime      <= 1'b0;
      timeUp       <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      digits       <= digits_nxt;
      timerRunning <= (state_nxt == ST_RUNNING);
      lowTime      <= low_nxt;
      timeUp       <= expire;
    end
  end

  assign digitHundreds = digits.hundreds;
  assign digitTens     = digits.tens;
  assign digitOnes     = digits.ones;

  // Header rectangle is zero-latency so it lines up with the current pixel
  assign InsideRectangle = ({1'b0, pixelX} >= X_LO) && ({1'b0, pixelX} < X_HI) &&
                           ({1'b0, pixelY} >= Y_LO) && ({1'b0, pixelY} < Y_HI);
  assign offsetX = pixelX - 11'(HEADER_X);
  assign offsetY = pixelY - 11'(HEADER_Y);

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - directed self-checking bench for game_timer
module tb_game_timer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        a_start, a_pause, a_bonus;
  logic        b_start, b_pause, b_bonus;
  logic [10:0] pixelX, pixelY;

  logic [10:0] a_offx, a_offy, b_offx, b_offy;
  logic        a_in, b_in;
  logic [3:0]  a_h, a_t, a_o, b_h, b_t, b_o;
  logic        a_run, a_low, a_up, b_run, b_low, b_up;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_timer #(.TICKS_PER_SEC(4), .START_SECONDS(150), .BONUS_SECONDS(10)) u_a (
    .clk(clk), .resetN(resetN), .startGame(a_start), .pause(a_pause), .bonusAdd(a_bonus),
    .pixelX(pixelX), .pixelY(pixelY), .offsetX(a_offx), .offsetY(a_offy),
    .InsideRectangle(a_in), .digitHundreds(a_h), .digitTens(a_t), .digitOnes(a_o),
    .timerRunning(a_run), .lowTime(a_low), .timeUp(a_up)
  );

  game_timer #(.TICKS_PER_SEC(4), .START_SECONDS(995), .BONUS_SECONDS(10)) u_b (
    .clk(clk), .resetN(resetN), .startGame(b_start), .pause(b_pause), .bonusAdd(b_bonus),
    .pixelX(pixelX), .pixelY(pixelY), .offsetX(b_offx), .offsetY(b_offy),
    .InsideRectangle(b_in), .digitHundreds(b_h), .digitTens(b_t), .digitOnes(b_o),
    .timerRunning(b_run), .lowTime(b_low), .timeUp(b_up)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int a_val();
    return int'({a_h, a_t, a_o});
  endfunction

  function automatic int b_val();
    return int'({b_h, b_t, b_o});
  endfunction

  task automatic pulse_a_start();
    a_start = 1'b1; step(1); a_start = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    a_start = 0; a_pause = 0; a_bonus = 0;
    b_start = 0; b_pause = 0; b_bonus = 0;
    pixelX = 0; pixelY = 0;
    step(3);
    resetN = 1'b1;
    step(1);

    check_val("rst_digits", a_val(), 'h150);
    check_val("rst_run", int'(a_run), 0);
    check_val("rst_low", int'(a_low), 0);
    check_val("rst_up", int'(a_up), 0);
    check_val("rst_b_digits", b_val(), 'h995);

    // header rectangle sweep
    for (int x = 15; x <= 48; x++) begin
      pixelX = 11'(x); pixelY = 11'd8;
      #1;
      check_val($sformatf("in_x%0d", x), int'(a_in), (x >= 16 && x <= 47) ? 1 : 0);
      if (x >= 16 && x <= 47) check_val($sformatf("offx_%0d", x), int'(a_offx), x - 16);
    end
    pixelX = 11'd20; pixelY = 11'd24; #1;
    check_val("in_y24", int'(a_in), 0);
    pixelY = 11'd23; #1;
    check_val("in_y23", int'(a_in), 1);
    check_val("offy_23", int'(a_offy), 15);
    pixelY = 11'd7; #1;
    check_val("in_y7", int'(a_in), 0);

    // idle does not count, bonus ignored in idle
    step(10);
    check_val("idle_hold", a_val(), 'h150);
    a_bonus = 1; step(1); a_bonus = 0;
    check_val("idle_bonus", a_val(), 'h150);

    // start and first tick
    pulse_a_start();
    check_val("start_run", int'(a_run), 1);
    step(3);
    check_val("pre_tick", a_val(), 'h150);
    step(1);
    check_val("tick_149", a_val(), 'h149);

    // pause mid-second with prescaler at 2
    step(2);
    a_pause = 1; step(20);
    check_val("pause_digits", a_val(), 'h149);
    check_val("pause_run", int'(a_run), 0);
    check_val("pause_low", int'(a_low), 0);
    a_bonus = 1; step(1); a_bonus = 0;
    check_val("pause_bonus", a_val(), 'h159);
    a_pause = 0; step(1);
    check_val("resume_run", int'(a_run), 1);
    step(1);
    check_val("resume_hold", a_val(), 'h159);
    step(1);
    check_val("resume_tick", a_val(), 'h158);

    // borrow across two digits
    step(232);
    check_val("val_100", a_val(), 'h100);
    step(4);
    check_val("borrow_099", a_val(), 'h099);
    check_val("low_099", int'(a_low), 0);
    step(352);
    check_val("val_011", a_val(), 'h011);
    check_val("low_011", int'(a_low), 0);
    step(4);
    check_val("val_010", a_val(), 'h010);
    check_val("low_010", int'(a_low), 1);
    step(36);
    check_val("val_001", a_val(), 'h001);

    // bonus coincident with tick at 001
    step(3);
    a_bonus = 1; step(1); a_bonus = 0;
    check_val("bonus_tick", a_val(), 'h010);
    check_val("bonus_tick_up", int'(a_up), 0);
    check_val("bonus_tick_run", int'(a_run), 1);

    // expiry
    step(39);
    check_val("pre_exp", a_val(), 'h001);
    check_val("pre_exp_up", int'(a_up), 0);
    step(1);
    check_val("exp_digits", a_val(), 'h000);
    check_val("exp_up", int'(a_up), 1);
    check_val("exp_run", int'(a_run), 0);
    check_val("exp_low", int'(a_low), 0);
    step(1);
    check_val("exp_up_once", int'(a_up), 0);
    step(8);
    check_val("exp_hold", a_val(), 'h000);
    a_bonus = 1; step(1); a_bonus = 0;
    check_val("exp_bonus", a_val(), 'h000);

    // restart from expired, then start beats pause
    pulse_a_start();
    check_val("restart_digits", a_val(), 'h150);
    check_val("restart_run", int'(a_run), 1);
    a_start = 1; a_pause = 1; step(1);
    check_val("prio_run", int'(a_run), 1);
    a_start = 0; step(1);
    check_val("prio_paused", int'(a_run), 0);
    a_pause = 0;

    // asynchronous reset mid-count
    step(2);
    resetN = 1'b0; #1;
    check_val("arst_digits", a_val(), 'h150);
    check_val("arst_run", int'(a_run), 0);
    check_val("arst_up", int'(a_up), 0);
    step(1);
    resetN = 1'b1;
    step(4);
    check_val("arst_idle", a_val(), 'h150);

    // saturation at 999
    b_start = 1; step(1); b_start = 0;
    check_val("b_start", b_val(), 'h995);
    b_bonus = 1; step(1); b_bonus = 0;
    check_val("b_sat", b_val(), 'h999);
    step(3);
    check_val("b_tick", b_val(), 'h998);
    step(3);
    b_bonus = 1; step(1); b_bonus = 0;
    check_val("b_sat_tick", b_val(), 'h999);
    check_val("b_low", int'(b_low), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
